// File: rtl/uart_cmd_ctrl.sv
// Command-line controller: collects a line, matches it against a command table,
// dispatches the command id, waits for completion and reports OK/error via the printer.
module uart_cmd_ctrl #(
  parameter int CMD_MAX_LEN = 8,
  parameter int NUM_CMDS    = 2,
  // Entry i char j lives at bits [(i*CMD_MAX_LEN+j)*8 +: 8]: entry 0 "led", entry 1 "ping"
  parameter logic [NUM_CMDS*CMD_MAX_LEN*8-1:0] CMD_TABLE =
    {64'h00000000_676e6970, 64'h00000000_0064656c},
  parameter logic [7:0] TERM_CHAR = 8'h0D,
  parameter int RUN_TIMEOUT = 1000,
  parameter int STR_ID_W    = 2,
  parameter int OK_STR_ID   = 1,
  parameter int ERR_STR_ID  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  input  logic                start_done,
  input  logic                printer_done,
  output logic                printer_enable,
  output logic [STR_ID_W-1:0] printer_str_id,
  output logic                cmd_valid,
  output logic [2:0]          cmd_id,
  input  logic                cmd_done,
  output logic [1:0]          err_code,
  output logic                busy,
  output logic [7:0]          drop_count
);

  localparam int PTR_W  = $clog2(CMD_MAX_LEN + 1);
  localparam int LINE_W = CMD_MAX_LEN * 8;

  typedef enum logic [2:0] {WAIT_START, READ, MATCH, RUN, OK, ERROR} state_t;

  state_t             state, next_state;
  logic [LINE_W-1:0]  line_buf;
  logic [PTR_W-1:0]   ptr, ptr_dec;
  logic               ovf;
  logic [31:0]        timer;
  logic               match_found;
  logic [2:0]         match_idx;

  assign ptr_dec        = ptr - 1'b1;
  assign printer_enable = (state == OK) || (state == ERROR);
  assign printer_str_id = (state == OK)    ? STR_ID_W'(OK_STR_ID)  :
                          (state == ERROR) ? STR_ID_W'(ERR_STR_ID) : '0;

  // Full-line compare including zero padding; scanning downward makes the lowest index win
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    for (int i = NUM_CMDS - 1; i >= 0; i--) begin
      if (line_buf == CMD_TABLE[i*LINE_W +: LINE_W]) begin
        match_found = 1'b1;
        match_idx   = 3'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_START;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      WAIT_START: if (start_done) next_state = READ;
      READ: begin
        if (rx_valid && rx_data == TERM_CHAR) begin
          if (ovf)            next_state = ERROR;
          else if (ptr != '0) next_state = MATCH;
        end
      end
      MATCH: next_state = match_found ? RUN : ERROR;
      RUN: begin
        if (cmd_done)
          next_state = OK;
        else if (RUN_TIMEOUT != 0 && timer == 32'(RUN_TIMEOUT - 1))
          next_state = ERROR;
      end
      OK, ERROR: if (printer_done) next_state = READ;
      default: next_state = WAIT_START;
    endcase
  end

  // Busy is registered so it reads 0 during reset yet tracks "not READ" afterwards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_buf   <= '0;
      ptr        <= '0;
      ovf        <= 1'b0;
      timer      <= '0;
      cmd_valid  <= 1'b0;
      cmd_id     <= '0;
      err_code   <= '0;
      busy       <= 1'b0;
      drop_count <= '0;
    end else begin
      cmd_valid <= 1'b0;
      busy      <= (next_state != READ);
      if (rx_valid && state != READ && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
      case (state)
        READ: begin
          if (rx_valid) begin
            if (rx_data == TERM_CHAR) begin
              if (ovf) err_code <= 2'd1;
            end else if (rx_data == 8'h08 || rx_data == 8'h7F) begin
              if (ptr != '0) begin
                ptr <= ptr_dec;
                line_buf[int'(ptr_dec)*8 +: 8] <= 8'h00;
              end
            end else if (ptr != PTR_W'(CMD_MAX_LEN)) begin
              line_buf[int'(ptr)*8 +: 8] <= rx_data;
              ptr <= ptr + 1'b1;
            end else begin
              ovf <= 1'b1;
            end
          end
        end
        MATCH: begin
          if (match_found) begin
            cmd_id    <= match_idx;
            cmd_valid <= 1'b1;
            timer     <= '0;
          end else begin
            err_code <= 2'd2;
          end
        end
        RUN: begin
          if (!cmd_done) begin
            if (next_state == ERROR) err_code <= 2'd3;
            else                     timer    <= timer + 32'd1;
          end
        end
        OK, ERROR: begin
          if (printer_done) begin
            line_buf <= '0;
            ptr      <= '0;
            ovf      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: table of command lines plus
// hand-written timeout, tie-break, drop-count and mid-print reset sequences.
module tb_uart_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       start_done;
  logic       printer_done;
  logic       printer_enable;
  logic [1:0] printer_str_id;
  logic       cmd_valid;
  logic [2:0] cmd_id;
  logic       cmd_done;
  logic [1:0] err_code;
  logic       busy;
  logic [7:0] drop_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      line;
    bit         dispatch;
    logic [2:0] id;
    logic [1:0] err;
  } vec_t;

  vec_t       vecs[9];
  logic [1:0] exp_err;
  bit         found;
  logic [2:0] got_id;
  bit         early;

  uart_cmd_ctrl dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .start_done(start_done), .printer_done(printer_done),
    .printer_enable(printer_enable), .printer_str_id(printer_str_id),
    .cmd_valid(cmd_valid), .cmd_id(cmd_id), .cmd_done(cmd_done),
    .err_code(err_code), .busy(busy), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string s, bit d, logic [2:0] id, logic [1:0] e);
    vec_t v;
    v.line = s; v.dispatch = d; v.id = id; v.err = e;
    return v;
  endfunction

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bytes(string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      rx_data  = s[i];
      rx_valid = 1'b1;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic wait_dispatch(output bit f, output logic [2:0] id);
    f  = 1'b0;
    id = '0;
    for (int c = 0; c < 10 && !f; c++) begin
      @(negedge clk);
      if (cmd_valid) begin
        f  = 1'b1;
        id = cmd_id;
      end
    end
  endtask

  task automatic finish_print(string tag, logic [1:0] exp_str, logic [1:0] e);
    int c = 0;
    while (!printer_enable && c < 50) begin
      @(negedge clk);
      c++;
    end
    check_output({tag, " printer_enable"}, printer_enable, 1);
    check_output({tag, " str_id"}, printer_str_id, exp_str);
    check_output({tag, " err_code"}, err_code, e);
    check_output({tag, " busy"}, busy, 1);
    printer_done = 1'b1;
    @(negedge clk);
    printer_done = 1'b0;
    check_output({tag, " enable released"}, printer_enable, 0);
    check_output({tag, " back to READ"}, busy, 0);
  endtask

  task automatic apply_stimulus(int idx);
    int seen = 0;
    int cnt  = 0;
    logic [2:0] id = '0;
    send_bytes(vecs[idx].line);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      cmd_done = 1'b0;
      if (printer_enable) break;
      if (cmd_valid) begin
        seen++;
        id  = cmd_id;
        cnt = 0;
        check_output($sformatf("vec%0d busy at dispatch", idx), busy, 1);
      end else if (seen > 0) begin
        cnt++;
      end
      if (vecs[idx].dispatch && seen > 0 && cnt == 4) cmd_done = 1'b1;
    end
    cmd_done = 1'b0;
    check_output($sformatf("vec%0d cmd_valid pulses", idx), seen, vecs[idx].dispatch ? 1 : 0);
    if (vecs[idx].dispatch) check_output($sformatf("vec%0d cmd_id", idx), id, vecs[idx].id);
    if (!vecs[idx].dispatch) exp_err = vecs[idx].err;
    finish_print($sformatf("vec%0d", idx), vecs[idx].dispatch ? 2'd1 : 2'd2, exp_err);
  endtask

  initial begin
    vecs[0] = mk("led\015", 1'b1, 3'd0, 2'd0);
    vecs[1] = mk("pinx\010g\015", 1'b1, 3'd1, 2'd0);
    vecs[2] = mk("abcdefghij\015", 1'b0, 3'd0, 2'd1);
    vecs[3] = mk("foo\015", 1'b0, 3'd0, 2'd2);
    vecs[4] = mk("pingg\177\015", 1'b1, 3'd1, 2'd0);
    vecs[5] = mk("le\015", 1'b0, 3'd0, 2'd2);
    vecs[6] = mk("ledx\015", 1'b0, 3'd0, 2'd2);
    vecs[7] = mk("pingabcdz\010\010\010\010\010\015", 1'b0, 3'd0, 2'd1);
    vecs[8] = mk("led\015", 1'b1, 3'd0, 2'd0);
    exp_err = 2'd0;

    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; start_done = 1'b0;
    printer_done = 1'b0; cmd_done = 1'b0;
    #12;
    check_output("reset printer_enable", printer_enable, 0);
    check_output("reset str_id", printer_str_id, 0);
    check_output("reset cmd_valid", cmd_valid, 0);
    check_output("reset err_code", err_code, 0);
    check_output("reset busy", busy, 0);
    check_output("reset drop_count", drop_count, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_output("busy in WAIT_START", busy, 1);
    start_done = 1'b1;
    @(negedge clk);
    start_done = 1'b0;
    check_output("busy in READ", busy, 0);

    send_bytes("\015");
    repeat (3) @(negedge clk);
    check_output("lone CR no print", printer_enable, 0);
    check_output("lone CR stays READ", busy, 0);
    check_output("lone CR no dispatch", cmd_valid, 0);

    for (int i = 0; i < 9; i++) apply_stimulus(i);
    check_output("no drops so far", drop_count, 0);

    // Timeout: ERROR must appear exactly 1000 cycles after the dispatch cycle
    send_bytes("led\015");
    wait_dispatch(found, got_id);
    check_output("timeout dispatch", found, 1);
    early = 1'b0;
    for (int k = 1; k < 1000; k++) begin
      @(negedge clk);
      if (printer_enable) early = 1'b1;
    end
    check_output("timeout not early", early, 0);
    @(negedge clk);
    check_output("timeout at 1000", printer_enable, 1);
    exp_err = 2'd3;
    finish_print("timeout", 2'd2, exp_err);

    // cmd_done in the same cycle as the timeout wins
    send_bytes("led\015");
    wait_dispatch(found, got_id);
    check_output("tie dispatch", found, 1);
    for (int k = 1; k < 1000; k++) @(negedge clk);
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    check_output("tie ok path", printer_enable, 1);
    finish_print("tie", 2'd1, exp_err);

    // Bytes arriving during RUN are dropped and counted, saturating
    send_bytes("ping\015");
    wait_dispatch(found, got_id);
    check_output("drop dispatch id", got_id, 1);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      rx_data  = 8'h41;
      rx_valid = 1'b1;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    finish_print("drop", 2'd1, exp_err);
    check_output("drop_count saturated", drop_count, 255);

    // Reset while the printer is being driven
    send_bytes("foo\015");
    for (int c = 0; c < 20 && !printer_enable; c++) @(negedge clk);
    check_output("pre-reset enable", printer_enable, 1);
    #2 rst = 1'b1;
    #1;
    check_output("async reset enable", printer_enable, 0);
    check_output("async reset str_id", printer_str_id, 0);
    check_output("async reset err_code", err_code, 0);
    check_output("async reset cmd_id", cmd_id, 0);
    check_output("async reset busy", busy, 0);
    check_output("async reset drop_count", drop_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Parametrised command-line controller covering the CMD_READ / CMD_RUN / ERROR phases of the UART command flow. It runs after the start banner completes. It collects received bytes into a line buffer and matches the line against a parameter command table. It then dispatches a command id to the executor, waits for completion or timeout, and reports OK or error through the printer's str_id/enable/done handshake.

Parameters:
CMD_MAX_LEN, 8, maximum stored characters per line (1..16)
NUM_CMDS, 2, number of command table entries (1..8)
CMD_TABLE, {"ping\0\0\0\0" packed, "led\0\0\0\0\0" packed}, NUM_CMDS*CMD_MAX_LEN*8 bits; entry i char j at bits [(i*CMD_MAX_LEN+j)*8 +: 8]; unused chars 8'h00
TERM_CHAR, 8'h0D, line terminator
RUN_TIMEOUT, 1000, clk cycles allowed in RUN; 0 disables the timeout
STR_ID_W, 2, printer str_id width
OK_STR_ID, 1, string printed on success
ERR_STR_ID, 2, string printed on any error

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe, rx_data valid
start_done  in  1  start banner finished (level or pulse)
printer_done  in  1  one-cycle pulse, string fully sent
printer_enable  out  1  request printer output
printer_str_id  out  STR_ID_W  string to print
cmd_valid  out  1  one-cycle dispatch strobe
cmd_id  out  3  matched entry index, held from dispatch until next dispatch
cmd_done  in  1  executor completion pulse
err_code  out  2  0 none, 1 overflow, 2 unknown, 3 timeout; latched until the next error or reset
busy  out  1  high in every state except READ
drop_count  out  8  saturating count of bytes discarded outside READ

Behaviour:
- Reset (async): state WAIT_START, ptr=0, ovf=0, all outputs 0, line buffer cleared to 8'h00.
- WAIT_START: start_done=1 -> READ on the next edge.
- READ, on each rx_valid:
  - TERM_CHAR with ptr=0 and ovf=0: ignored, stay in READ.
  - TERM_CHAR with ovf=1: -> ERROR, err_code=1.
  - TERM_CHAR otherwise: -> MATCH.
  - 8'h08 or 8'h7F: ptr decrements if ptr>0 and the vacated slot is cleared to 8'h00; ovf is unchanged.
  - Other byte with ptr<CMD_MAX_LEN: stored at buf[ptr], ptr++.
  - Other byte with ptr=CMD_MAX_LEN: byte dropped, ovf=1.
- MATCH: exactly 1 cycle.
  - Compare the whole buffer, including 00 padding, with every table entry in parallel.
  - Lowest matching index wins.
  - Match: cmd_id=index, cmd_valid=1 for this transition cycle only, -> RUN, timer=0.
  - No match: -> ERROR, err_code=2.
- RUN:
  - cmd_done=1 -> OK.
  - Else if RUN_TIMEOUT!=0 and timer==RUN_TIMEOUT-1 -> ERROR, err_code=3.
  - Else timer++.
  - cmd_done has priority over a timeout in the same cycle.
  - Latency: cmd_valid is registered and asserted the cycle after the TERM byte is accepted.
- OK / ERROR:
  - printer_enable=1 with printer_str_id=OK_STR_ID (OK) or ERR_STR_ID (ERROR), held until printer_done.
  - On printer_done: printer_enable=0 on the next edge, buffer cleared, ptr=0, ovf=0, -> READ.
  - printer_done outside OK/ERROR is ignored.
- rx_valid in any state other than READ: byte dropped, drop_count++ saturating at 255.
- cmd_done outside RUN is ignored.
- Reset mid-operation: immediate return to reset values; a pending printer_enable drops asynchronously.

Test Plan:
- Reset, then start_done pulse, then bytes "led",0D -> cmd_valid one cycle with cmd_id=0, busy=1. cmd_done 5 cycles later -> printer_enable=1, str_id=1. printer_done -> back to READ, busy=0.
- "pinx",08,"g",0D -> cmd_id=1 dispatched; the backspace removes 'x'.
- 10 bytes "abcdefghij" then 0D -> no cmd_valid, err_code=1, str_id=2 printed, then READ with ptr=0.
- "foo",0D -> err_code=2, printer_enable with str_id=2.
- "led",0D with no cmd_done for 1000 cycles -> ERROR at cycle 1000 with err_code=3. cmd_done and timeout in the same cycle -> OK path taken.
- 0D alone -> stays in READ, no print. 300 bytes sent during RUN -> drop_count=255. Reset asserted while printer_enable=1 -> all outputs 0 immediately.
